// File: rtl/cnn_tx_pkg.sv
// Shared state type, word width and default sizing for the CNN stream initiator.
package cnn_tx_pkg;

   localparam int WORD_W        = 16;
   localparam int FRAME_LEN_DEF = 45;
   localparam int GAP_CYC_DEF   = 2;
   localparam int TIMEOUT_DEF   = 1000;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SEND,
      WAIT,
      RECV,
      GAP
   } tx_state_e;

endpackage

// File: rtl/cnn_tx_frame_buf.sv
// One-frame register file: host side writes through wrPtr, SEND side reads through rdPtr.
module cnn_tx_frame_buf import cnn_tx_pkg::*; #(
   parameter int FRAME_LEN = FRAME_LEN_DEF,
   parameter int PTR_W     = $clog2(FRAME_LEN + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en_i,
   input  logic              wr_clr_i,
   input  logic [WORD_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   input  logic              rd_clr_i,
   output logic [WORD_W-1:0] rd_data_o,
   output logic [PTR_W-1:0]  wr_ptr_o,
   output logic              full_o,
   output logic              rd_first_o,
   output logic              rd_last_o
);

   localparam logic [PTR_W-1:0] LastIdx = PTR_W'(FRAME_LEN - 1);
   localparam logic [PTR_W-1:0] FullCnt = PTR_W'(FRAME_LEN);

   logic [WORD_W-1:0] mem_q [FRAME_LEN];
   logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
   logic              wrFire;

   assign wrFire = wr_en_i && !full_o;

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      if (wr_clr_i) begin
         wrPtr_d = '0;
      end else if (wrFire) begin
         wrPtr_d = wrPtr_q + 1'b1;
      end
      if (rd_clr_i) begin
         rdPtr_d = '0;
      end else if (rd_en_i) begin
         rdPtr_d = rdPtr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
      end
   end

   // Storage is intentionally left unreset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (wrFire) begin
         mem_q[wrPtr_q] <= wr_data_i;
      end
   end

   assign rd_data_o  = mem_q[rdPtr_q];
   assign wr_ptr_o   = wrPtr_q;
   assign full_o     = (wrPtr_q == FullCnt);
   assign rd_first_o = (rdPtr_q == '0);
   assign rd_last_o  = (rdPtr_q == LastIdx);

endmodule

// File: rtl/cnn_stream_tx.sv
// CNN stream initiator: buffers a host frame, bursts it to the CNN, forwards the result burst.
// Optional WAIT-state response timeout is enabled by defining CNN_TX_TIMEOUT_EN.
module cnn_stream_tx import cnn_tx_pkg::*; #(
   parameter int FRAME_LEN = FRAME_LEN_DEF,
   parameter int GAP_CYC   = GAP_CYC_DEF
`ifdef CNN_TX_TIMEOUT_EN
  ,parameter int TIMEOUT   = TIMEOUT_DEF
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              host_valid,
   output logic              host_ready,
   input  logic [WORD_W-1:0] host_data,
   input  logic              host_last,
   input  logic              host_opt,
   output logic              in_valid,
   output logic [WORD_W-1:0] in_data,
   output logic              opt,
   input  logic              out_valid,
   input  logic [WORD_W-1:0] out_data,
   output logic              res_valid,
   output logic [WORD_W-1:0] res_data,
   output logic              res_last,
   output logic [7:0]        res_cnt,
   output logic              err_len,
   output logic              err_proto,
   output logic              err_timeout
);

   localparam int              PtrW    = $clog2(FRAME_LEN + 1);
   localparam logic [PtrW-1:0] LastIdx = PtrW'(FRAME_LEN - 1);
   localparam int              GapW    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYC - 1);

   tx_state_e         state_q, state_d;
   logic              hostRdy, sending, listening;
   logic              accept, frameDone, lenErr, protoErr, capture, timeoutHit;
   logic              wrEn, wrClr, rdEn, rdClr;
   logic [WORD_W-1:0] rdData;
   logic [PtrW-1:0]   wrPtr;
   logic              bufFull, rdFirst, rdLast;
   logic              opt_q, resValid_q, errLen_q, errProto_q;
   logic [WORD_W-1:0] resData_q;
   logic [7:0]        burstCnt_q, resCnt_q;
   logic [GapW-1:0]   gapCnt_q;

   cnn_tx_frame_buf #(
      .FRAME_LEN (FRAME_LEN),
      .PTR_W     (PtrW)
   ) u_buf (
      .clk        (clk),
      .rst        (rst),
      .wr_en_i    (wrEn),
      .wr_clr_i   (wrClr),
      .wr_data_i  (host_data),
      .rd_en_i    (rdEn),
      .rd_clr_i   (rdClr),
      .rd_data_o  (rdData),
      .wr_ptr_o   (wrPtr),
      .full_o     (bufFull),
      .rd_first_o (rdFirst),
      .rd_last_o  (rdLast)
   );

   assign accept    = host_valid & hostRdy;
   assign frameDone = accept & (wrPtr == LastIdx);
   assign lenErr    = accept & host_last & ~frameDone;
   assign capture   = out_valid & listening;
   assign protoErr  = out_valid & ~listening;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (frameDone)   state_d = SEND;
            else if (lenErr) state_d = IDLE;
            else if (accept) state_d = LOAD;
         end
         LOAD: begin
            if (frameDone)   state_d = SEND;
            else if (lenErr) state_d = IDLE;
         end
         SEND: if (rdLast) state_d = WAIT;
         WAIT: begin
            if (out_valid)       state_d = RECV;
            else if (timeoutHit) state_d = IDLE;
         end
         RECV: if (!out_valid) state_d = GAP;
         GAP:  if (gapCnt_q == GapLast) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // host_ready is also masked by rst so every output reads 0 while reset is held.
   always_comb begin
      hostRdy   = 1'b0;
      sending   = 1'b0;
      listening = 1'b0;
      unique case (state_q)
         IDLE, LOAD: hostRdy   = 1'b1;
         SEND:       sending   = 1'b1;
         WAIT, RECV: listening = 1'b1;
         default:    ;
      endcase
      host_ready = hostRdy & ~rst;
      in_valid   = sending;
      in_data    = sending ? rdData : '0;
      opt        = sending & rdFirst & opt_q;
      res_last   = (state_q == RECV) & ~out_valid;
      wrEn       = accept;
      wrClr      = lenErr | (sending & rdLast);
      rdEn       = sending;
      rdClr      = sending & rdLast;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opt_q      <= 1'b0;
         resValid_q <= 1'b0;
         resData_q  <= '0;
         burstCnt_q <= '0;
         resCnt_q   <= '0;
         gapCnt_q   <= '0;
         errLen_q   <= 1'b0;
         errProto_q <= 1'b0;
      end else begin
         if (accept && state_q == IDLE) begin
            opt_q <= host_opt;
         end
         resValid_q <= capture;
         resData_q  <= capture ? out_data : '0;
         if (capture) begin
            if (state_q == WAIT)           burstCnt_q <= 8'd1;
            else if (burstCnt_q != 8'hFF)  burstCnt_q <= burstCnt_q + 1'b1;
         end
         if (state_q == RECV && !out_valid) begin
            resCnt_q <= burstCnt_q;
         end
         gapCnt_q   <= (state_q == GAP) ? gapCnt_q + 1'b1 : '0;
         errLen_q   <= lenErr;
         errProto_q <= protoErr;
      end
   end

`ifdef CNN_TX_TIMEOUT_EN
   localparam int             ToW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT - 1);

   logic [ToW-1:0] waitCnt_q;
   logic           errTimeout_q;

   assign timeoutHit = (state_q == WAIT) & ~out_valid & (waitCnt_q == ToLast);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         waitCnt_q    <= '0;
         errTimeout_q <= 1'b0;
      end else begin
         waitCnt_q    <= (state_q == WAIT) ? waitCnt_q + 1'b1 : '0;
         errTimeout_q <= timeoutHit;
      end
   end

   assign err_timeout = errTimeout_q;
`else
   assign timeoutHit  = 1'b0;
   assign err_timeout = 1'b0;
`endif

   assign res_valid = resValid_q;
   assign res_data  = resData_q;
   assign res_cnt   = resCnt_q;
   assign err_len   = errLen_q;
   assign err_proto = errProto_q;

endmodule

// File: tb/tb_cnn_stream_tx.sv
// Directed self-checking bench for cnn_stream_tx; timeout scenario follows CNN_TX_TIMEOUT_EN.
module tb_cnn_stream_tx;
   import cnn_tx_pkg::*;

   logic        clk, rst;
   logic        host_valid, host_ready, host_last, host_opt;
   logic [15:0] host_data;
   logic        in_valid, opt;
   logic [15:0] in_data;
   logic        out_valid;
   logic [15:0] out_data;
   logic        res_valid, res_last;
   logic [15:0] res_data;
   logic [7:0]  res_cnt;
   logic        err_len, err_proto, err_timeout;

   int nChecks = 0;
   int nFails  = 0;

   cnn_stream_tx dut (
      .clk         (clk),
      .rst         (rst),
      .host_valid  (host_valid),
      .host_ready  (host_ready),
      .host_data   (host_data),
      .host_last   (host_last),
      .host_opt    (host_opt),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .opt         (opt),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .res_valid   (res_valid),
      .res_data    (res_data),
      .res_last    (res_last),
      .res_cnt     (res_cnt),
      .err_len     (err_len),
      .err_proto   (err_proto),
      .err_timeout (err_timeout)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed no end of test, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single comparison point: counts and reports on mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nChecks++;
      assert (observed === expected)
      else begin
         nFails++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Push words base+1..base+lastAt, host_last on word lastAt, option bit on word 1 only.
   task automatic applyStimulus(input logic [15:0] base, input logic optBit, input int lastAt);
      checkOutput("host_ready_before_load", host_ready, 1'b1);
      for (int i = 1; i <= lastAt; i++) begin
         host_valid = 1'b1;
         host_data  = base + 16'(i);
         host_opt   = (i == 1) ? optBit : ~optBit;
         host_last  = (i == lastAt);
         tick();
      end
      host_valid = 1'b0;
      host_last  = 1'b0;
      host_opt   = 1'b0;
      host_data  = '0;
   endtask

   // Follow the send burst word by word; optional single out_valid glitch during SEND.
   task automatic sendCheck(input logic [15:0] base, input logic optBit, input int glitchAt, input int nWords);
      for (int k = 1; k <= nWords; k++) begin
         #1;
         checkOutput("in_valid_send", in_valid, 1'b1);
         checkOutput("in_data_send", in_data, base + 16'(k));
         checkOutput("opt_send", opt, (k == 1) ? optBit : 1'b0);
         if (k == 1) checkOutput("host_ready_send", host_ready, 1'b0);
         if (glitchAt != 0 && k == glitchAt + 1) begin
            checkOutput("err_proto_pulse", err_proto, 1'b1);
            checkOutput("res_valid_glitch", res_valid, 1'b0);
         end
         if (glitchAt != 0 && k == glitchAt + 2) checkOutput("err_proto_clear", err_proto, 1'b0);
         out_valid = (k == glitchAt);
         out_data  = 16'hDEAD;
         if (k < nWords || nWords == FRAME_LEN_DEF) tick();
      end
      if (nWords == FRAME_LEN_DEF) begin
         #1;
         checkOutput("in_valid_after_send", in_valid, 1'b0);
         checkOutput("in_data_after_send", in_data, 16'h0000);
      end
   endtask

   // CNN returns n words base..base+n-1, then the GAP window is checked.
   task automatic respond(input logic [15:0] base, input int n);
      out_valid = 1'b1;
      out_data  = base;
      for (int j = 0; j < n; j++) begin
         tick();
         if (j < n - 1) begin
            out_data = base + 16'(j + 1);
         end else begin
            out_valid = 1'b0;
            out_data  = '0;
         end
         #1;
         checkOutput("res_valid", res_valid, 1'b1);
         checkOutput("res_data", res_data, base + 16'(j));
         checkOutput("res_last", res_last, (j == n - 1));
      end
      tick();
      checkOutput("res_valid_gap", res_valid, 1'b0);
      checkOutput("res_last_gap", res_last, 1'b0);
      checkOutput("res_cnt", res_cnt, 8'(n));
      checkOutput("host_ready_gap1", host_ready, 1'b0);
      tick();
      checkOutput("host_ready_gap2", host_ready, 1'b0);
      tick();
      checkOutput("host_ready_after_gap", host_ready, 1'b1);
   endtask

   initial begin
      int  waitCycles;
      logic sawTimeout;

      rst        = 1'b1;
      host_valid = 1'b0;
      host_data  = '0;
      host_last  = 1'b0;
      host_opt   = 1'b0;
      out_valid  = 1'b0;
      out_data   = '0;
      $display("[TB] starting cnn_stream_tx directed test");

      repeat (2) tick();
      checkOutput("rst_host_ready", host_ready, 1'b0);
      checkOutput("rst_in_valid", in_valid, 1'b0);
      checkOutput("rst_res_valid", res_valid, 1'b0);
      checkOutput("rst_res_cnt", res_cnt, 8'h00);
      checkOutput("rst_err_len", err_len, 1'b0);
      checkOutput("rst_err_proto", err_proto, 1'b0);
      checkOutput("rst_err_timeout", err_timeout, 1'b0);
      rst = 1'b0;
      tick();
      checkOutput("idle_host_ready", host_ready, 1'b1);

      // Full frame 1..45 with option set, four-word result.
      applyStimulus(16'h0000, 1'b1, 45);
      sendCheck(16'h0000, 1'b1, 0, 45);
      respond(16'hA000, 4);

      // host_last on word 10 drops the frame.
      applyStimulus(16'h0100, 1'b0, 10);
      #1;
      checkOutput("err_len_pulse", err_len, 1'b1);
      checkOutput("in_valid_len_err", in_valid, 1'b0);
      checkOutput("host_ready_len_err", host_ready, 1'b1);
      tick();
      checkOutput("err_len_clear", err_len, 1'b0);
      checkOutput("in_valid_len_err2", in_valid, 1'b0);

      // out_valid glitch in the middle of a send, then a single-word result.
      applyStimulus(16'h0200, 1'b0, 45);
      sendCheck(16'h0200, 1'b0, 5, 45);
      respond(16'h1234, 1);

      applyStimulus(16'h0300, 1'b1, 45);
      sendCheck(16'h0300, 1'b1, 0, 45);
`ifdef CNN_TX_TIMEOUT_EN
      waitCycles = 0;
      while (err_timeout !== 1'b1 && waitCycles < 3 * TIMEOUT_DEF) begin
         tick();
         waitCycles++;
      end
      checkOutput("timeout_cycles", waitCycles, TIMEOUT_DEF);
      checkOutput("host_ready_after_timeout", host_ready, 1'b1);
      out_valid = 1'b1;
      out_data  = 16'h7777;
      tick();
      out_valid = 1'b0;
      out_data  = '0;
      #1;
      checkOutput("err_proto_late", err_proto, 1'b1);
      checkOutput("res_valid_late", res_valid, 1'b0);
      tick();
`else
      sawTimeout = 1'b0;
      waitCycles = 0;
      repeat (5 * TIMEOUT_DEF) begin
         tick();
         waitCycles++;
         if (err_timeout !== 1'b0) sawTimeout = 1'b1;
      end
      checkOutput("no_timeout_pulse", sawTimeout, 1'b0);
      checkOutput("wait_host_ready", host_ready, 1'b0);
      checkOutput("wait_in_valid", in_valid, 1'b0);
      checkOutput("wait_err_proto", err_proto, 1'b0);
      respond(16'h5000, 2);
`endif

      // Reset during send word 20, then a clean frame.
      applyStimulus(16'h0400, 1'b1, 45);
      sendCheck(16'h0400, 1'b1, 0, 20);
      rst = 1'b1;
      #1;
      checkOutput("midrst_in_valid", in_valid, 1'b0);
      checkOutput("midrst_in_data", in_data, 16'h0000);
      checkOutput("midrst_opt", opt, 1'b0);
      checkOutput("midrst_host_ready", host_ready, 1'b0);
      checkOutput("midrst_res_cnt", res_cnt, 8'h00);
      checkOutput("midrst_res_valid", res_valid, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      applyStimulus(16'h0500, 1'b1, 45);
      sendCheck(16'h0500, 1'b1, 0, 45);
      respond(16'hB000, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/cnn_stream_tx.md
# cnn_stream_tx

Initiator-side driver for the CNN accelerator stream interface (`in_valid`/`in_data`/`opt` out, `out_valid`/`out_data` back). It buffers one frame from a host push port, sends the frame to the CNN as one uninterrupted `in_valid` burst, then captures the CNN result burst and forwards it to the host. It sits between the host/DMA logic and the CNN core, and replaces the bench stimulus driver in integrated builds.

## Interface
- `FRAME_LEN`, 45: words per frame (36 image + 9 kernel).
- `GAP_CYC`, 2: idle cycles enforced after `out_valid` falls, before the next `in_valid`.
- `TIMEOUT`, 1000: maximum cycles from end of send to first `out_valid`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `host_valid` in 1: host frame word valid.
- `host_ready` out 1: buffer accepts a word.
- `host_data` in 16: frame word.
- `host_last` in 1: host marks its last word.
- `host_opt` in 1: option bit, sampled with word 0 only.
- `in_valid` out 1, `in_data` out 16, `opt` out 1: to CNN.
- `out_valid` in 1, `out_data` in 16: from CNN.
- `res_valid` out 1, `res_data` out 16, `res_last` out 1: result stream to host, no backpressure.
- `res_cnt` out 8: word count of the last completed result burst.
- `err_len`, `err_proto`, `err_timeout` out 1 each: single-cycle error pulses.

## Operation
- States: IDLE, LOAD, SEND, WAIT, RECV, GAP.
- IDLE/LOAD: `host_ready`=1. A word transfers when `host_valid & host_ready`. The first word moves IDLE to LOAD and latches `host_opt`. The frame completes on word FRAME_LEN, then the state goes to SEND. `host_last` on the final word is optional.
- `host_last` on any word before word FRAME_LEN pulses `err_len`, drops the frame, and returns to IDLE.
- SEND: `in_valid`=1 for exactly FRAME_LEN consecutive cycles, with `in_data`=buf[0..FRAME_LEN-1] in order. `opt` carries the latched bit on the first cycle only and is 0 otherwise. `host_ready`=0.
- Whenever `in_valid`=0, `in_data` and `opt` are driven to 0.
- WAIT: entered the cycle after the last send word. The first `out_valid`=1 moves the state to RECV.
- RECV: each `out_valid` word is registered to `res_data`/`res_valid`, and a counter increments (saturates at 255).
- When `out_valid` falls: `res_last` is asserted with the final delayed word, `res_cnt` loads the count, and the state goes to GAP.
- GAP: holds GAP_CYC cycles with `host_ready`=0, then goes to IDLE.
- `out_valid`=1 in IDLE, LOAD, SEND or GAP pulses `err_proto`. The data is discarded and the state is unchanged.
- A zero-length result is impossible by construction; RECV requires at least one word.

## Timing
- Reset values: all outputs 0, `res_cnt`=0, state IDLE, frame write/read pointers 0. Buffer contents are not reset.
- Reset mid-burst aborts immediately. `in_valid` drops asynchronously, and no partial-frame resume occurs.
- Latency: last host word accepted at cycle t gives the first `in_valid` at t+1.
- `out_valid` to `res_valid`: exactly 1 cycle. `res_last` rises 1 cycle after `out_valid` falls, together with the last `res_valid`.
- Error pulses are asserted 1 cycle after the triggering condition.
- `in_valid` and `out_valid` never overlap as driven by this block. The minimum `out_valid`-fall to next `in_valid` distance is GAP_CYC+1+FRAME_LEN cycles (a reload is required).

## Configuration
- `CNN_TX_TIMEOUT_EN` defined: a WAIT-state counter runs. On reaching TIMEOUT with no `out_valid`, `err_timeout` pulses and the state goes to IDLE. A late `out_valid` then raises `err_proto`.
- `CNN_TX_TIMEOUT_EN` undefined: WAIT holds indefinitely, and `err_timeout` is tied to 0.

## Structure
- Package `cnn_tx_pkg` holds:
  - the state enum;
  - the default FRAME_LEN/GAP_CYC/TIMEOUT constants;
  - the 16-bit word width constant.
- Sub-module `cnn_tx_frame_buf`: FRAME_LEN×16 register file with a write pointer (host side) and a read pointer (SEND side), plus `full` and `rd_last` flags.
- The top level holds the FSM, the result capture register, and the counters.

## Test plan
- Frame of words 1..45 with `host_opt`=1 → `in_valid` high for 45 cycles, `in_data` 1..45, `opt`=1 only on cycle 1; first `in_valid` is 1 cycle after word 45 is accepted.
- CNN returns 4 words 0xA000..0xA003 → `res_valid` 4 cycles with 1-cycle delay, `res_last` on 0xA003, `res_cnt`=4, then GAP_CYC cycles with `host_ready`=0.
- `host_last` on word 10 → `err_len` pulse, no `in_valid`, back to IDLE with `host_ready`=1.
- `out_valid` pulse during SEND → `err_proto` pulse, send continues uninterrupted, no `res_valid`.
- With `CNN_TX_TIMEOUT_EN` and no CNN response → `err_timeout` pulses after 1000 WAIT cycles, then IDLE. Without the macro → still in WAIT at cycle 5000.
- `rst` asserted at send word 20 → `in_valid`=0 immediately, all outputs 0. After release, a fresh full frame sends correctly.
